// File: rtl/chan_mux_rr.sv
// N-channel valid/ready multiplexer with fixed-select or round-robin arbitration
// feeding a single registered output stage.
module chan_mux_rr #(
   parameter int N_CH  = 4,
   parameter int WIDTH = 8,
   localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [N_CH*WIDTH-1:0] in_data,
   input  logic [N_CH-1:0]       in_valid,
   output logic [N_CH-1:0]       in_ready,
   input  logic                  mode,
   input  logic [SEL_W-1:0]      sel,
   output logic [WIDTH-1:0]      out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [SEL_W-1:0]      out_ch,
   output logic [N_CH-1:0]       grant
);

   logic [SEL_W-1:0] ptr;
   logic [SEL_W-1:0] gnt_idx;
   logic [WIDTH-1:0] gnt_data;
   logic             load_en;
   logic             xfer;
   logic             found;
   int               idx;

   // Round-robin search starts one past the last granted channel, wrapping at N_CH.
   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = 0;
      if (N_CH == 1) begin
         grant[0] = in_valid[0];
      end else if (!mode) begin
         for (int i = 0; i < N_CH; i++) begin
            if (int'(sel) == i) grant[i] = in_valid[i];
         end
      end else begin
         for (int k = 1; k <= N_CH; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N_CH) idx = idx - N_CH;
            if (!found && in_valid[idx]) begin
               grant[idx] = 1'b1;
               found      = 1'b1;
            end
         end
      end
   end

   always_comb begin
      gnt_idx  = '0;
      gnt_data = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (grant[i]) begin
            gnt_idx  = SEL_W'(i);
            gnt_data = in_data[i*WIDTH +: WIDTH];
         end
      end
   end

   assign load_en  = !out_valid || out_ready;
   assign in_ready = grant & {N_CH{load_en}};
   assign xfer     = |in_ready;

   // A load overrides a drain so back-to-back words flow at one per cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ch    <= '0;
         ptr       <= SEL_W'(N_CH - 1);
      end else if (xfer) begin
         out_valid <= 1'b1;
         out_data  <= gnt_data;
         out_ch    <= gnt_idx;
         ptr       <= gnt_idx;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_chan_mux_rr.sv
// Scoreboard bench for chan_mux_rr: directed vectors push expected words, a
// negedge monitor pops them whenever the output stage hands a word off.
module tb_chan_mux_rr;

   typedef struct packed {
      logic [7:0] d;
      logic [1:0] ch;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] in_data;
   logic [3:0]  in_valid;
   logic [3:0]  in_ready;
   logic        mode;
   logic [1:0]  sel;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready;
   logic [1:0]  out_ch;
   logic [3:0]  grant;

   logic [7:0]  dat [4];
   exp_t        expQ [$];
   int          vecCount  = 0;
   int          failCount = 0;

   assign in_data = {dat[3], dat[2], dat[1], dat[0]};

   chan_mux_rr #(.N_CH(4), .WIDTH(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .mode      (mode),
      .sel       (sel),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_ch    (out_ch),
      .grant     (grant)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
      vecCount++;
      if (act !== expv) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
      end
   endtask

   // One cycle: drive inputs after the edge, check arbitration, queue the word it loads.
   task automatic applyStimulus(input logic [3:0] v, input logic m, input logic [1:0] s,
                                input logic ordy, input logic [3:0] expGrant,
                                input logic [3:0] expReady);
      @(posedge clk);
      #1;
      in_valid  = v;
      mode      = m;
      sel       = s;
      out_ready = ordy;
      #1;
      checkOutput("grant", 32'(grant), 32'(expGrant));
      checkOutput("in_ready", 32'(in_ready), 32'(expReady));
      for (int i = 0; i < 4; i++) begin
         if (expReady[i]) expQ.push_back('{d: dat[i], ch: 2'(i)});
      end
   endtask

   task automatic checkRegs(input string tag, input logic v, input logic [7:0] d, input logic [1:0] c);
      checkOutput({tag, "_out_valid"}, 32'(out_valid), 32'(v));
      checkOutput({tag, "_out_data"}, 32'(out_data), 32'(d));
      checkOutput({tag, "_out_ch"}, 32'(out_ch), 32'(c));
   endtask

   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (expQ.size() == 0) begin
            vecCount++;
            failCount++;
            $display("[TB] FAIL unexpected_word: got %0h ch %0d expected none", out_data, out_ch);
         end else begin
            exp_t e;
            e = expQ.pop_front();
            checkOutput("sb_out_data", 32'(out_data), 32'(e.d));
            checkOutput("sb_out_ch", 32'(out_ch), 32'(e.ch));
         end
      end
   end

   initial begin
      #20000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_n     = 1'b0;
      in_valid  = '0;
      mode      = 1'b0;
      sel       = '0;
      out_ready = 1'b0;
      dat[0] = 8'h10; dat[1] = 8'h11; dat[2] = 8'hA5; dat[3] = 8'h13;
      #3;
      checkRegs("reset", 1'b0, 8'h00, 2'd0);
      #9 rst_n = 1'b1;

      // Fixed select of channel 2.
      applyStimulus(4'b0100, 1'b0, 2'd2, 1'b1, 4'b0100, 4'b0100);
      applyStimulus(4'b0000, 1'b1, 2'd0, 1'b1, 4'b0000, 4'b0000);
      checkRegs("fixed", 1'b1, 8'hA5, 2'd2);
      dat[2] = 8'h12;

      // Round robin, all channels valid, pointer left at 2.
      applyStimulus(4'b1111, 1'b1, 2'd0, 1'b1, 4'b1000, 4'b1000);
      applyStimulus(4'b1111, 1'b1, 2'd0, 1'b1, 4'b0001, 4'b0001);
      applyStimulus(4'b1111, 1'b1, 2'd0, 1'b1, 4'b0010, 4'b0010);
      applyStimulus(4'b1111, 1'b1, 2'd0, 1'b1, 4'b0100, 4'b0100);
      applyStimulus(4'b1111, 1'b1, 2'd0, 1'b1, 4'b1000, 4'b1000);
      applyStimulus(4'b1111, 1'b1, 2'd0, 1'b1, 4'b0001, 4'b0001);

      // Only channels 1 and 3 requesting.
      applyStimulus(4'b1010, 1'b1, 2'd0, 1'b1, 4'b0010, 4'b0010);
      applyStimulus(4'b1010, 1'b1, 2'd0, 1'b1, 4'b1000, 4'b1000);
      applyStimulus(4'b1010, 1'b1, 2'd0, 1'b1, 4'b0010, 4'b0010);
      applyStimulus(4'b1010, 1'b1, 2'd0, 1'b1, 4'b1000, 4'b1000);

      // Stall for three cycles holding channel 3's word.
      for (int n = 0; n < 3; n++) begin
         applyStimulus(4'b1111, 1'b1, 2'd0, 1'b0, 4'b0001, 4'b0000);
         checkRegs("stall", 1'b1, 8'h13, 2'd3);
      end
      applyStimulus(4'b1111, 1'b1, 2'd0, 1'b1, 4'b0001, 4'b0001);

      // Fixed select of an idle channel, then switch to round robin.
      applyStimulus(4'b0001, 1'b0, 2'd1, 1'b1, 4'b0000, 4'b0000);
      applyStimulus(4'b0001, 1'b1, 2'd1, 1'b1, 4'b0001, 4'b0001);
      applyStimulus(4'b0000, 1'b1, 2'd0, 1'b0, 4'b0000, 4'b0000);
      checkRegs("held", 1'b1, 8'h10, 2'd0);

      // Asynchronous reset while a word is held.
      #1 rst_n = 1'b0;
      #1;
      checkRegs("async_reset", 1'b0, 8'h00, 2'd0);
      expQ.delete();
      @(posedge clk);
      #3 rst_n = 1'b1;

      applyStimulus(4'b1111, 1'b1, 2'd0, 1'b1, 4'b0001, 4'b0001);
      applyStimulus(4'b1100, 1'b1, 2'd0, 1'b1, 4'b0100, 4'b0100);
      applyStimulus(4'b0000, 1'b1, 2'd0, 1'b1, 4'b0000, 4'b0000);
      applyStimulus(4'b0000, 1'b1, 2'd0, 1'b1, 4'b0000, 4'b0000);
      checkRegs("drained", 1'b0, 8'h12, 2'd2);
      checkOutput("queue_empty", 32'(expQ.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, failCount);
      $finish;
   end

endmodule
